// File: rtl/modport_alu_if.sv
// Command/operand and result bundle for modport_alu.
//   master: drives CE, MODE, CIN, INP_VALID, CMD, OPA, OPB; samples the results
//   slave : samples the command/operands; drives RES, COUT, OFLOW, G, L, E, ERR
interface modport_alu_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
);
    logic                   CE;
    logic                   MODE;
    logic                   CIN;
    logic [1:0]             INP_VALID;
    logic [CMD_WIDTH-1:0]   CMD;
    logic [WIDTH-1:0]       OPA;
    logic [WIDTH-1:0]       OPB;
    logic [2*WIDTH-1:0]     RES;
    logic                   COUT;
    logic                   OFLOW;
    logic                   G;
    logic                   L;
    logic                   E;
    logic                   ERR;

    modport master (
        output CE, MODE, CIN, INP_VALID, CMD, OPA, OPB,
        input  RES, COUT, OFLOW, G, L, E, ERR
    );

    modport slave (
        input  CE, MODE, CIN, INP_VALID, CMD, OPA, OPB,
        output RES, COUT, OFLOW, G, L, E, ERR
    );
endinterface

// File: rtl/modport_alu.sv
// Registered, clock-enabled integer ALU.
//   MODE=1: add/sub (with carry/borrow in), inc/dec, compare, optional multiplies.
//   MODE=0: bitwise logic, single-bit shifts, rotates of OPA by OPB.
// Ports:
//   CLK : rising-edge clock
//   RST : asynchronous active-high reset, clears all outputs
//   bus : modport_alu_if.slave (CE, MODE, CIN, INP_VALID, CMD, OPA, OPB in;
//         RES, COUT, OFLOW, G, L, E, ERR out)
// Build option: define ALU_MULT_EN to implement MODE=1 CMD 9/10 as a two-stage
// pipeline (every op then takes 2 cycles so results leave in issue order);
// otherwise those commands report ERR with 1-cycle latency.
module modport_alu #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    modport_alu_if.slave bus
);
    localparam int SH = $clog2(WIDTH);

    localparam logic [CMD_WIDTH-1:0] A_ADD  = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] A_SUB  = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] A_ADDC = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] A_SUBC = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] A_INCA = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] A_DECA = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] A_INCB = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] A_DECB = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] A_CMP  = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] A_MULI = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] A_MULS = CMD_WIDTH'(10);

    localparam logic [CMD_WIDTH-1:0] L_AND  = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] L_NAND = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] L_OR   = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] L_NOR  = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] L_XOR  = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] L_XNOR = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] L_NOTA = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] L_NOTB = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] L_SRA  = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] L_SLA  = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] L_SRB  = CMD_WIDTH'(10);
    localparam logic [CMD_WIDTH-1:0] L_SLB  = CMD_WIDTH'(11);
    localparam logic [CMD_WIDTH-1:0] L_ROL  = CMD_WIDTH'(12);
    localparam logic [CMD_WIDTH-1:0] L_ROR  = CMD_WIDTH'(13);

    typedef struct packed {
        logic [2*WIDTH-1:0] res;
        logic               cout;
        logic               oflow;
        logic               g;
        logic               l;
        logic               e;
        logic               err;
    } out_t;

    logic [WIDTH:0]   a_x, b_x;
    logic [WIDTH:0]   x, y, cx, sum;
    logic [WIDTH-1:0] lres;
    logic [SH-1:0]    amt;
    logic             need_a, need_b, legal, use_add, sub;
    out_t             nx, q;
`ifdef ALU_MULT_EN
    logic               is_mul;
    logic [2*WIDTH-1:0] ma, mb;
`endif

    assign a_x = {1'b0, bus.OPA};
    assign b_x = {1'b0, bus.OPB};
    assign amt = bus.OPB[SH-1:0];

    always_comb begin
        nx      = '0;
        need_a  = 1'b0;
        need_b  = 1'b0;
        legal   = 1'b1;
        use_add = 1'b0;
        sub     = 1'b0;
        x       = '0;
        y       = '0;
        cx      = '0;
        sum     = '0;
        lres    = '0;
`ifdef ALU_MULT_EN
        is_mul  = 1'b0;
        ma      = '0;
        mb      = '0;
`endif
        if (bus.MODE) begin
            // All add/sub/inc/dec share one W+1-bit adder: x +/- y +/- cx.
            case (bus.CMD)
                A_ADD:  begin need_a = 1'b1; need_b = 1'b1; use_add = 1'b1; x = a_x; y = b_x; end
                A_SUB:  begin need_a = 1'b1; need_b = 1'b1; use_add = 1'b1; sub = 1'b1; x = a_x; y = b_x; end
                A_ADDC: begin need_a = 1'b1; need_b = 1'b1; use_add = 1'b1; x = a_x; y = b_x;
                              cx = {{WIDTH{1'b0}}, bus.CIN}; end
                A_SUBC: begin need_a = 1'b1; need_b = 1'b1; use_add = 1'b1; sub = 1'b1; x = a_x; y = b_x;
                              cx = {{WIDTH{1'b0}}, bus.CIN}; end
                A_INCA: begin need_a = 1'b1; use_add = 1'b1; x = a_x; cx = (WIDTH+1)'(1); end
                A_DECA: begin need_a = 1'b1; use_add = 1'b1; sub = 1'b1; x = a_x; cx = (WIDTH+1)'(1); end
                A_INCB: begin need_b = 1'b1; use_add = 1'b1; x = b_x; cx = (WIDTH+1)'(1); end
                A_DECB: begin need_b = 1'b1; use_add = 1'b1; sub = 1'b1; x = b_x; cx = (WIDTH+1)'(1); end
                A_CMP:  begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    nx.g   = bus.OPA > bus.OPB;
                    nx.l   = bus.OPA < bus.OPB;
                    nx.e   = bus.OPA == bus.OPB;
                end
`ifdef ALU_MULT_EN
                A_MULI: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    is_mul = 1'b1;
                    ma     = (2*WIDTH)'(a_x + (WIDTH+1)'(1));
                    mb     = (2*WIDTH)'(b_x + (WIDTH+1)'(1));
                end
                A_MULS: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    is_mul = 1'b1;
                    ma     = (2*WIDTH)'(WIDTH'(bus.OPA << 1));
                    mb     = (2*WIDTH)'(bus.OPB);
                end
`endif
                default: legal = 1'b0;
            endcase
            sum = sub ? (x - y - cx) : (x + y + cx);
            if (use_add) begin
                // Subtraction: bit WIDTH of the wrapped difference is the borrow.
                if (sub) begin
                    nx.res   = (2*WIDTH)'(sum[WIDTH-1:0]);
                    nx.oflow = sum[WIDTH];
                end else begin
                    nx.res   = (2*WIDTH)'(sum);
                    nx.cout  = sum[WIDTH];
                end
            end
        end else begin
            case (bus.CMD)
                L_AND:  begin need_a = 1'b1; need_b = 1'b1; lres = bus.OPA & bus.OPB; end
                L_NAND: begin need_a = 1'b1; need_b = 1'b1; lres = ~(bus.OPA & bus.OPB); end
                L_OR:   begin need_a = 1'b1; need_b = 1'b1; lres = bus.OPA | bus.OPB; end
                L_NOR:  begin need_a = 1'b1; need_b = 1'b1; lres = ~(bus.OPA | bus.OPB); end
                L_XOR:  begin need_a = 1'b1; need_b = 1'b1; lres = bus.OPA ^ bus.OPB; end
                L_XNOR: begin need_a = 1'b1; need_b = 1'b1; lres = ~(bus.OPA ^ bus.OPB); end
                L_NOTA: begin need_a = 1'b1; lres = ~bus.OPA; end
                L_NOTB: begin need_b = 1'b1; lres = ~bus.OPB; end
                L_SRA:  begin need_a = 1'b1; lres = bus.OPA >> 1; end
                L_SLA:  begin need_a = 1'b1; lres = bus.OPA << 1; end
                L_SRB:  begin need_b = 1'b1; lres = bus.OPB >> 1; end
                L_SLB:  begin need_b = 1'b1; lres = bus.OPB << 1; end
                // Rotate by shifting the doubled operand and keeping one WIDTH-bit window.
                L_ROL:  begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    lres   = WIDTH'(({bus.OPA, bus.OPA} << amt) >> WIDTH);
                    nx.err = |(bus.OPB >> SH);
                end
                L_ROR:  begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    lres   = WIDTH'({bus.OPA, bus.OPA} >> amt);
                    nx.err = |(bus.OPB >> SH);
                end
                default: legal = 1'b0;
            endcase
            nx.res = (2*WIDTH)'(lres);
        end

        if (!legal || (need_a && !bus.INP_VALID[0]) || (need_b && !bus.INP_VALID[1])) begin
            nx     = '0;
            nx.err = 1'b1;
`ifdef ALU_MULT_EN
            is_mul = 1'b0;
`endif
        end
    end

`ifdef ALU_MULT_EN
    // Stage 1 registers operands; stage 2 multiplies. Non-multiply results ride
    // along in stage 1 so every command leaves in issue order.
    out_t               s1;
    logic               s1_mul;
    logic [2*WIDTH-1:0] s1_ma, s1_mb;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1     <= '0;
            s1_mul <= 1'b0;
            s1_ma  <= '0;
            s1_mb  <= '0;
            q      <= '0;
        end else if (bus.CE) begin
            s1     <= nx;
            s1_mul <= is_mul;
            s1_ma  <= ma;
            s1_mb  <= mb;
            q      <= s1;
            if (s1_mul) q.res <= s1_ma * s1_mb;
        end
    end
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         q <= '0;
        else if (bus.CE) q <= nx;
    end
`endif

    assign bus.RES   = q.res;
    assign bus.COUT  = q.cout;
    assign bus.OFLOW = q.oflow;
    assign bus.G     = q.g;
    assign bus.L     = q.l;
    assign bus.E     = q.e;
    assign bus.ERR   = q.err;
endmodule

// File: tb/tb_modport_alu.sv
// Scoreboard bench for modport_alu: the stimulus process pushes the expected
// result of each issued command; an independent monitor pops and compares on
// every CE=1 edge and checks that outputs hold on CE=0 edges.
module tb_modport_alu;
    localparam int W = 8;
`ifdef ALU_MULT_EN
    localparam int LAT  = 2;
    localparam bit MULT = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit MULT = 1'b0;
`endif

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           cout;
        logic           oflow;
        logic           g;
        logic           l;
        logic           e;
        logic           err;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    modport_alu_if #(.WIDTH(W), .CMD_WIDTH(4)) bus_if ();
    modport_alu #(.WIDTH(W), .CMD_WIDTH(4)) dut (.CLK(CLK), .RST(RST), .bus(bus_if.slave));

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   rst_gen = 0;

    function automatic exp_t model(bit mode, bit cin, bit [1:0] iv, int cmd, int a, int b);
        exp_t r;
        int   v, amt, mask;
        bit   na, nb, ok;
        r    = '0;
        mask = (1 << W) - 1;
        na = 0; nb = 0; ok = 1;
        if (mode) begin
            if (cmd inside {0, 1, 2, 3, 8, 9, 10}) begin na = 1; nb = 1; end
            else if (cmd inside {4, 5}) na = 1;
            else if (cmd inside {6, 7}) nb = 1;
            else ok = 0;
            if (cmd inside {9, 10} && !MULT) ok = 0;
        end else begin
            if (cmd inside {0, 1, 2, 3, 4, 5, 12, 13}) begin na = 1; nb = 1; end
            else if (cmd inside {6, 8, 9}) na = 1;
            else if (cmd inside {7, 10, 11}) nb = 1;
            else ok = 0;
        end
        if (!ok || (na && !iv[0]) || (nb && !iv[1])) begin
            r.err = 1'b1;
            return r;
        end
        if (mode) begin
            case (cmd)
                0, 2, 4, 6: begin
                    v = (cmd == 0) ? a + b : (cmd == 2) ? a + b + int'(cin) : (cmd == 4) ? a + 1 : b + 1;
                    r.res  = (2*W)'(v);
                    r.cout = v > mask;
                end
                1, 3, 5, 7: begin
                    v = (cmd == 1) ? a - b : (cmd == 3) ? a - b - int'(cin) : (cmd == 5) ? a - 1 : b - 1;
                    r.res   = (2*W)'(v & mask);
                    r.oflow = v < 0;
                end
                8: begin
                    r.g = a > b;
                    r.l = a < b;
                    r.e = a == b;
                end
                9:  r.res = (2*W)'((a + 1) * (b + 1));
                10: r.res = (2*W)'(((a * 2) & mask) * b);
                default: r.err = 1'b1;
            endcase
        end else begin
            amt = b % W;
            case (cmd)
                0:  v = a & b;
                1:  v = ~(a & b);
                2:  v = a | b;
                3:  v = ~(a | b);
                4:  v = a ^ b;
                5:  v = ~(a ^ b);
                6:  v = ~a;
                7:  v = ~b;
                8:  v = a / 2;
                9:  v = a * 2;
                10: v = b / 2;
                11: v = b * 2;
                12: v = (a << amt) | (a >> (W - amt));
                default: v = (a >> amt) | (a << (W - amt));
            endcase
            r.res = (2*W)'(v & mask);
            if (cmd >= 12) r.err = b >= W;
        end
        return r;
    endfunction

    function automatic exp_t dut_out();
        return {bus_if.RES, bus_if.COUT, bus_if.OFLOW, bus_if.G, bus_if.L, bus_if.E, bus_if.ERR};
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got res=%h cout=%b oflow=%b g=%b l=%b e=%b err=%b, expected res=%h cout=%b oflow=%b g=%b l=%b e=%b err=%b",
                     name, $time, got.res, got.cout, got.oflow, got.g, got.l, got.e, got.err,
                     exp.res, exp.cout, exp.oflow, exp.g, exp.l, exp.e, exp.err);
        end
    endtask

    task automatic issue(input bit ce, input bit mode, input int cmd, input int a, input int b,
                         input bit [1:0] iv, input bit cin);
        @(negedge CLK);
        bus_if.CE        = ce;
        bus_if.MODE      = mode;
        bus_if.CMD       = 4'(cmd);
        bus_if.OPA       = W'(a);
        bus_if.OPB       = W'(b);
        bus_if.INP_VALID = iv;
        bus_if.CIN       = cin;
        if (ce) exp_q.push_back(model(mode, cin, iv, cmd, a, b));
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        bus_if.CE = 1'b0;
        #2 RST = 1'b1;
        #1 check("reset_async", dut_out(), '0);
        #1 RST = 1'b0;
        exp_q.delete();
        rst_gen++;
    endtask

    // Monitor: output after an edge with CE=1 is the next scoreboard entry
    // (or reset contents while the pipeline refills); with CE=0 it must hold.
    initial begin
        int   edges = 0;
        int   seen  = 0;
        exp_t last  = '0;
        exp_t e;
        bit   ce_s, rst_s;
        forever begin
            @(posedge CLK);
            if (seen != rst_gen) begin
                seen  = rst_gen;
                edges = 0;
                last  = '0;
            end
            ce_s  = bus_if.CE;
            rst_s = RST;
            #2;
            if (rst_s) continue;
            if (ce_s) begin
                edges++;
                if (edges < LAT) begin
                    e = '0;
                end else if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_empty @%0t: got an update, expected a queued result", $time);
                    continue;
                end else begin
                    e = exp_q.pop_front();
                end
                last = e;
                check("update", dut_out(), e);
            end else begin
                check("hold", dut_out(), last);
            end
        end
    end

    initial begin
        bus_if.CE = 1'b0; bus_if.MODE = 1'b0; bus_if.CIN = 1'b0; bus_if.INP_VALID = 2'b00;
        bus_if.CMD = '0; bus_if.OPA = '0; bus_if.OPB = '0;
        #1 check("reset_state", dut_out(), '0);
        #11 RST = 1'b0;
        rst_gen++;

        issue(1, 1, 0,  'hFF, 'h01, 2'b11, 0);  // ADD carry
        issue(1, 1, 1,  'h03, 'h05, 2'b11, 0);  // SUB borrow
        issue(1, 1, 8,  'h05, 'h05, 2'b11, 0);  // CMP equal
        issue(1, 1, 8,  'h07, 'h05, 2'b11, 0);  // CMP greater
        issue(1, 0, 12, 'h81, 'h01, 2'b11, 0);  // ROL
        issue(1, 0, 12, 'h81, 'h11, 2'b11, 0);  // ROL bad amount
        issue(1, 0, 13, 'h81, 'h03, 2'b11, 0);  // ROR
        issue(1, 0, 0,  'h0F, 'hF0, 2'b01, 0);  // missing B
        issue(1, 0, 6,  'h0F, 'h00, 2'b01, 0);  // NOT_A needs only A
        issue(1, 1, 0,  'h01, 'h01, 2'b00, 0);  // no operands
        issue(1, 1, 3,  'h05, 'h05, 2'b11, 1);  // SUB_CIN A<B+CIN
        issue(1, 1, 2,  'hFF, 'hFF, 2'b11, 1);  // ADD_CIN max
        issue(1, 1, 5,  'h00, 'h00, 2'b01, 0);  // DEC_A underflow
        issue(1, 1, 7,  'h00, 'h00, 2'b10, 0);  // DEC_B underflow
        issue(1, 1, 9,  'h02, 'h03, 2'b11, 0);  // (A+1)*(B+1)
        issue(1, 1, 10, 'hC1, 'h03, 2'b11, 0);  // (A<<1)*B
        issue(1, 0, 15, 'h12, 'h34, 2'b11, 0);  // unlisted
        issue(1, 1, 4,  'hFF, 'h00, 2'b01, 0);  // INC_A carry
        for (int i = 0; i < 3; i++) issue(0, 1, 0, i, i, 2'b11, 0);  // hold
        issue(1, 1, 6,  'h10, 'h20, 2'b10, 0);
        issue(1, 1, 0,  'h11, 'h22, 2'b11, 0);
        pulse_reset();
        for (int i = 0; i < 2; i++) issue(0, 0, 0, 'h55, 'hAA, 2'b11, 0);

        for (int i = 0; i < 500; i++) begin
            int a, b, cmd;
            bit [1:0] iv;
            a   = int'($urandom_range(0, (1 << W) - 1));
            b   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : int'($urandom_range(0, (1 << W) - 1));
            cmd = int'($urandom_range(0, 15));
            iv  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            issue($urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)), cmd, a, b, iv, 1'($urandom_range(0, 1)));
            if (i % 150 == 149) pulse_reset();
        end
        for (int i = 0; i < LAT + 1; i++) issue(1, 0, 2, 'h0F, 'h30, 2'b11, 0);
        issue(0, 0, 0, 0, 0, 2'b11, 0);
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
